// File: rtl/axi_lite_4reg_selftest_master_if.sv
// rtl/axi_lite_4reg_selftest_master_if.sv - AXI4-Lite bus bundle between the self-test master and the register slave
interface axi_lite_4reg_selftest_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axi_lite_4reg_selftest_master.sv
// rtl/axi_lite_4reg_selftest_master.sv - AXI4-Lite write/readback self-test sequencer for the 4-register slave
module axi_lite_4reg_selftest_master #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
    parameter int                            C_NUM_REGS         = 4,
    parameter int                            C_TIMEOUT          = 1023
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          start,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] seed,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [2:0]                    err_cnt,
    output logic                          timeout,
    axi_lite_4reg_selftest_master_if.master m_axi
);
    localparam int ADDR_W = C_M_AXI_ADDR_WIDTH;
    localparam int DATA_W = C_M_AXI_DATA_WIDTH;
    localparam int IDX_W  = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
    localparam int CNT_W  = $clog2(C_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(C_NUM_REGS - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(C_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_REQ,
        S_RD_RESP,
        S_FINISH
    } state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [DATA_W-1:0]   seed_q, seed_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                busy_n, done_n, pass_n, timeout_n;
    logic [2:0]          err_n;
    logic                awvalid_q, awvalid_n;
    logic                wvalid_q, wvalid_n;
    logic                bready_q, bready_n;
    logic                arvalid_q, arvalid_n;
    logic                rready_q, rready_n;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_n;
    logic [ADDR_W-1:0]   araddr_q, araddr_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic                stall;
    logic [IDX_W-1:0]    idx_inc;
    logic                is_last;
    logic                rd_bad;

    function automatic logic [ADDR_W-1:0] reg_addr(input logic [IDX_W-1:0] i);
        return C_BASE_ADDR + (ADDR_W'(i) << 2);
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s, input logic [IDX_W-1:0] i);
        return s + DATA_W'(i);
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] c);
        return (c == 3'd7) ? c : c + 3'd1;
    endfunction

    assign idx_inc = idx + IDX_W'(1);
    assign is_last = (idx == LAST_IDX);
    // A bad data word and a bad response on the same beat are one error.
    assign rd_bad  = (m_axi.rdata != pattern(seed_q, idx)) || (m_axi.rresp != 2'b00);

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign m_axi.araddr  = araddr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;

    // Next state and next value of every registered output.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        seed_n    = seed_q;
        cnt_n     = '0;
        busy_n    = busy;
        done_n    = 1'b0;
        pass_n    = pass;
        err_n     = err_cnt;
        timeout_n = timeout;
        awvalid_n = awvalid_q;
        wvalid_n  = wvalid_q;
        bready_n  = bready_q;
        arvalid_n = arvalid_q;
        rready_n  = rready_q;
        awaddr_n  = awaddr_q;
        wdata_n   = wdata_q;
        araddr_n  = araddr_q;
        stall     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    seed_n    = seed;
                    idx_n     = '0;
                    err_n     = '0;
                    pass_n    = 1'b0;
                    timeout_n = 1'b0;
                    busy_n    = 1'b1;
                    awvalid_n = 1'b1;
                    wvalid_n  = 1'b1;
                    awaddr_n  = reg_addr('0);
                    wdata_n   = seed;
                    state_n   = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                // The pending valid flags double as the aw/w done trackers.
                awvalid_n = awvalid_q & ~m_axi.awready;
                wvalid_n  = wvalid_q & ~m_axi.wready;
                if (awvalid_n || wvalid_n) begin
                    stall = 1'b1;
                end else begin
                    bready_n = 1'b1;
                    state_n  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (m_axi.bvalid) begin
                    bready_n = 1'b0;
                    if (m_axi.bresp != 2'b00) begin
                        err_n = sat_inc(err_cnt);
                    end
                    if (is_last) begin
                        idx_n     = '0;
                        arvalid_n = 1'b1;
                        araddr_n  = reg_addr('0);
                        state_n   = S_RD_REQ;
                    end else begin
                        idx_n     = idx_inc;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        awaddr_n  = reg_addr(idx_inc);
                        wdata_n   = pattern(seed_q, idx_inc);
                        state_n   = S_WR_REQ;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (m_axi.arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = S_RD_RESP;
                end else begin
                    stall = 1'b1;
                end
            end
            S_RD_RESP: begin
                if (m_axi.rvalid) begin
                    rready_n = 1'b0;
                    if (rd_bad) begin
                        err_n = sat_inc(err_cnt);
                    end
                    if (is_last) begin
                        done_n  = 1'b1;
                        pass_n  = (err_n == 3'd0) && !timeout;
                        state_n = S_FINISH;
                    end else begin
                        idx_n     = idx_inc;
                        arvalid_n = 1'b1;
                        araddr_n  = reg_addr(idx_inc);
                        state_n   = S_RD_REQ;
                    end
                end else begin
                    stall = 1'b1;
                end
            end
            S_FINISH: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Phase watchdog: abort the whole test and leave the bus quiet.
        if (stall) begin
            if (cnt == CNT_LIMIT) begin
                timeout_n = 1'b1;
                pass_n    = 1'b0;
                done_n    = 1'b1;
                awvalid_n = 1'b0;
                wvalid_n  = 1'b0;
                bready_n  = 1'b0;
                arvalid_n = 1'b0;
                rready_n  = 1'b0;
                state_n   = S_FINISH;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state     <= S_IDLE;
            idx       <= '0;
            seed_q    <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            timeout   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            araddr_q  <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            seed_q    <= seed_n;
            cnt       <= cnt_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            err_cnt   <= err_n;
            timeout   <= timeout_n;
            awvalid_q <= awvalid_n;
            wvalid_q  <= wvalid_n;
            bready_q  <= bready_n;
            arvalid_q <= arvalid_n;
            rready_q  <= rready_n;
            awaddr_q  <= awaddr_n;
            wdata_q   <= wdata_n;
            araddr_q  <= araddr_n;
        end
    end
endmodule

// File: tb/tb_axi_lite_4reg_selftest_master.sv
// tb/tb_axi_lite_4reg_selftest_master.sv - directed self-checking bench for the AXI4-Lite self-test master
module tb_axi_lite_4reg_selftest_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] seed = 32'h0;
    logic        busy, done, pass, timeout;
    logic [2:0]  err_cnt;

    axi_lite_4reg_selftest_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_4reg_selftest_master #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_BASE_ADDR(32'h0000_0000),
        .C_NUM_REGS(4),
        .C_TIMEOUT(15)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESET(rst),
        .start(start),
        .seed(seed),
        .busy(busy),
        .done(done),
        .pass(pass),
        .err_cnt(err_cnt),
        .timeout(timeout),
        .m_axi(bus)
    );

    always #5 clk = ~clk;

    // Slave model configuration.
    int aw_dly [4];
    int w_dly [4];
    int stuck_idx;
    int bresp_err_idx;
    int rerr_idx;
    bit ar_never;

    // Slave model state.
    logic [31:0] mem [4];
    logic        aw_got = 1'b0, w_got = 1'b0;
    logic [31:0] aw_l = 32'h0, w_l = 32'h0;
    int          aw_cnt = 0, w_cnt = 0;
    int          aw_n = 0, w_n = 0, done_n = 0, ar_hi = 0;
    logic        aw_hs, w_hs, commit;
    logic [31:0] c_addr, c_data;

    assign bus.awready = (aw_cnt >= aw_dly[bus.awaddr[3:2]]);
    assign bus.wready  = (w_cnt >= w_dly[bus.awaddr[3:2]]);
    assign bus.arready = !ar_never;
    assign aw_hs  = bus.awvalid && bus.awready;
    assign w_hs   = bus.wvalid && bus.wready;
    assign commit = (aw_got || aw_hs) && (w_got || w_hs);
    assign c_addr = aw_hs ? bus.awaddr : aw_l;
    assign c_data = w_hs ? bus.wdata : w_l;

    // Register slave: commit a write once address and data are both in, respond next cycle.
    always @(posedge clk) begin
        if (rst) begin
            aw_got     <= 1'b0;
            w_got      <= 1'b0;
            aw_cnt     <= 0;
            w_cnt      <= 0;
            bus.bvalid <= 1'b0;
            bus.bresp  <= 2'b00;
            bus.rvalid <= 1'b0;
            bus.rresp  <= 2'b00;
            bus.rdata  <= 32'h0;
        end else begin
            if (aw_hs) begin
                aw_l   <= bus.awaddr;
                aw_n   <= aw_n + 1;
                aw_cnt <= 0;
            end else if (bus.awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (w_hs) begin
                w_l   <= bus.wdata;
                w_n   <= w_n + 1;
                w_cnt <= 0;
            end else if (bus.wvalid) begin
                w_cnt <= w_cnt + 1;
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (commit) begin
                aw_got             <= 1'b0;
                w_got              <= 1'b0;
                mem[c_addr[3:2]]   <= c_data;
                bus.bvalid         <= 1'b1;
                bus.bresp          <= (int'(c_addr[3:2]) == bresp_err_idx) ? 2'b10 : 2'b00;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs) w_got <= 1'b1;
            end
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
            if (bus.arvalid && bus.arready) begin
                bus.rvalid <= 1'b1;
                bus.rresp  <= (int'(bus.araddr[3:2]) == rerr_idx) ? 2'b10 : 2'b00;
                bus.rdata  <= (int'(bus.araddr[3:2]) == stuck_idx) ? 32'h0 :
                              (mem[bus.araddr[3:2]] ^ ((int'(bus.araddr[3:2]) == rerr_idx) ? 32'h0000_0100 : 32'h0));
            end
        end
    end

    // Event counters sampled on the clock edge.
    always @(posedge clk) begin
        if (done) done_n <= done_n + 1;
        if (bus.arvalid) ar_hi <= ar_hi + 1;
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_default();
        for (int i = 0; i < 4; i++) begin
            aw_dly[i] = 0;
            w_dly[i]  = 0;
        end
        stuck_idx     = -1;
        bresp_err_idx = -1;
        rerr_idx      = -1;
        ar_never      = 1'b0;
    endtask

    // Pulse start, optionally poke a second start mid-test, and wait for done.
    task automatic run(input logic [31:0] s, input int poke, input logic [31:0] pseed,
                       output int cyc, output bit seen);
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        seen  = 1'b0;
        while (cyc < 100) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
            if (cyc == poke) begin
                start = 1'b1;
                seed  = pseed;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic chk_mem(input string tag, input logic [31:0] m0, input logic [31:0] m1,
                           input logic [31:0] m2, input logic [31:0] m3);
        chk({tag, "_mem0"}, mem[0], m0);
        chk({tag, "_mem1"}, mem[1], m1);
        chk({tag, "_mem2"}, mem[2], m2);
        chk({tag, "_mem3"}, mem[3], m3);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_err"}, 32'(err_cnt), 32'h0);
        chk({tag, "_awvalid"}, 32'(bus.awvalid), 32'h0);
        chk({tag, "_wvalid"}, 32'(bus.wvalid), 32'h0);
        chk({tag, "_bready"}, 32'(bus.bready), 32'h0);
        chk({tag, "_arvalid"}, 32'(bus.arvalid), 32'h0);
        chk({tag, "_rready"}, 32'(bus.rready), 32'h0);
        chk({tag, "_awaddr"}, bus.awaddr, 32'h0);
        chk({tag, "_wdata"}, bus.wdata, 32'h0);
        chk({tag, "_araddr"}, bus.araddr, 32'h0);
    endtask

    initial begin
        int  cyc;
        bit  seen;
        int  aw0, w0, d0, a0;
        bit  found;

        cfg_default();
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state.
        chk_idle_outputs("reset");
        chk("reset_pass", 32'(pass), 32'h0);
        chk("reset_timeout", 32'(timeout), 32'h0);
        chk("reset_wstrb", 32'(bus.wstrb), 32'hF);
        chk("reset_awprot", 32'(bus.awprot), 32'h0);
        chk("reset_arprot", 32'(bus.arprot), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait slave, seed 1, with a start poked while busy.
        aw0 = aw_n; w0 = w_n; d0 = done_n;
        run(32'h1, 5, 32'hAAAA_0000, cyc, seen);
        chk("t1_done_seen", 32'(seen), 32'h1);
        chk("t1_cycles", cyc, 17);
        chk("t1_pass", 32'(pass), 32'h1);
        chk("t1_err", 32'(err_cnt), 32'h0);
        chk("t1_timeout", 32'(timeout), 32'h0);
        chk("t1_busy_in_done", 32'(busy), 32'h1);
        chk_mem("t1", 32'h1, 32'h2, 32'h3, 32'h4);
        chk("t1_aw_xfers", aw_n - aw0, 4);
        chk("t1_w_xfers", w_n - w0, 4);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 32'h0);
        chk("t1_done_after", 32'(done), 32'h0);
        chk("t1_pass_held", 32'(pass), 32'h1);
        @(negedge clk);
        chk("t1_done_pulses", done_n - d0, 1);

        // Register 2 stuck at zero: wrap-around seed still passes.
        stuck_idx = 2;
        run(32'hFFFF_FFFE, 0, 32'h0, cyc, seen);
        chk("t2a_done_seen", 32'(seen), 32'h1);
        chk("t2a_cycles", cyc, 17);
        chk("t2a_pass", 32'(pass), 32'h1);
        chk("t2a_err", 32'(err_cnt), 32'h0);
        chk_mem("t2a", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        @(negedge clk);
        run(32'h10, 0, 32'h0, cyc, seen);
        chk("t2b_done_seen", 32'(seen), 32'h1);
        chk("t2b_pass", 32'(pass), 32'h0);
        chk("t2b_err", 32'(err_cnt), 32'h1);
        chk_mem("t2b", 32'h10, 32'h11, 32'h12, 32'h13);
        @(negedge clk);

        // Address late on write 0, data late on write 1.
        cfg_default();
        aw_dly[0] = 3;
        w_dly[1]  = 3;
        aw0 = aw_n; w0 = w_n;
        run(32'h55, 0, 32'h0, cyc, seen);
        chk("t3_done_seen", 32'(seen), 32'h1);
        chk("t3_cycles", cyc, 23);
        chk("t3_pass", 32'(pass), 32'h1);
        chk("t3_err", 32'(err_cnt), 32'h0);
        chk("t3_aw_xfers", aw_n - aw0, 4);
        chk("t3_w_xfers", w_n - w0, 4);
        chk_mem("t3", 32'h55, 32'h56, 32'h57, 32'h58);
        @(negedge clk);

        // Bad write response on reg 1, bad read response plus bad data on reg 3.
        cfg_default();
        bresp_err_idx = 1;
        rerr_idx      = 3;
        run(32'h1000, 0, 32'h0, cyc, seen);
        chk("t4_done_seen", 32'(seen), 32'h1);
        chk("t4_cycles", cyc, 17);
        chk("t4_pass", 32'(pass), 32'h0);
        chk("t4_err", 32'(err_cnt), 32'h2);
        chk("t4_timeout", 32'(timeout), 32'h0);
        @(negedge clk);

        // Slave never accepts a read address.
        cfg_default();
        ar_never = 1'b1;
        a0 = ar_hi; d0 = done_n;
        run(32'h20, 0, 32'h0, cyc, seen);
        chk("t5_done_seen", 32'(seen), 32'h1);
        chk("t5_cycles", cyc, 24);
        chk("t5_timeout", 32'(timeout), 32'h1);
        chk("t5_pass", 32'(pass), 32'h0);
        chk("t5_err", 32'(err_cnt), 32'h0);
        chk("t5_arvalid_low", 32'(bus.arvalid), 32'h0);
        repeat (3) @(negedge clk);
        chk("t5_arvalid_cycles", ar_hi - a0, 15);
        chk("t5_done_pulses", done_n - d0, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cfg_default();
        chk("t5_timeout_cleared", 32'(timeout), 32'h0);
        @(negedge clk);

        // Reset while waiting for a write response.
        d0 = done_n;
        @(negedge clk);
        start = 1'b1;
        seed  = 32'h7;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.bready) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_reached_wr_resp", 32'(found), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("t6_after_reset");
        rst = 1'b0;
        @(negedge clk);
        chk("t6_no_done", done_n - d0, 0);
        run(32'h7, 0, 32'h0, cyc, seen);
        chk("t6_done_seen", 32'(seen), 32'h1);
        chk("t6_cycles", cyc, 17);
        chk("t6_pass", 32'(pass), 32'h1);
        chk("t6_err", 32'(err_cnt), 32'h0);
        chk_mem("t6", 32'h7, 32'h8, 32'h9, 32'hA);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/axi_lite_4reg_selftest_master.md
# axi_lite_4reg_selftest_master

AXI4-Lite master sequencer that sits directly upstream of the 4-register AXI4-Lite slave and drives its S_AXI port in hardware.
- On a start pulse it writes a seed-derived pattern to every register, reads each one back, compares the data and checks every response code.
- It reports pass/fail, an error count and a timeout flag.
- It is the synthesizable on-chip equivalent of the simulation write/readback check, used for board bring-up and built-in self-test.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_BASE_ADDR, 32'h0000_0000, byte address of register 0.
- C_NUM_REGS, 4, number of registers; the register stride is 4 bytes.
- C_TIMEOUT, 1023, maximum cycles to wait on any single handshake phase.

Ports:
- M_AXI_ACLK  in  1  single clock; all logic is on its rising edge.
- M_AXI_ARESET  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to run the test; ignored while busy.
- seed  in  32  pattern seed, sampled when start is accepted.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  result of the last test; held until the next accepted start.
- err_cnt  out  3  mismatches plus non-OKAY responses; saturates at 7.
- timeout  out  1  last test aborted on a handshake timeout.
- M_AXI_AWADDR out ADDR_W; M_AXI_AWPROT out 3 (always 3'b000); M_AXI_AWVALID out 1; M_AXI_AWREADY in 1.
- M_AXI_WDATA out 32; M_AXI_WSTRB out 4 (always 4'hF); M_AXI_WVALID out 1; M_AXI_WREADY in 1.
- M_AXI_BRESP in 2; M_AXI_BVALID in 1; M_AXI_BREADY out 1.
- M_AXI_ARADDR out ADDR_W; M_AXI_ARPROT out 3 (always 3'b000); M_AXI_ARVALID out 1; M_AXI_ARREADY in 1.
- M_AXI_RDATA in 32; M_AXI_RRESP in 2; M_AXI_RVALID in 1; M_AXI_RREADY out 1.

## Operation
States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FINISH.
- Index i runs over the registers. Register i is at address C_BASE_ADDR + 4*i and receives pattern seed + i, computed modulo 2^32.
- IDLE, start=1: latch seed, set i=0, clear err_cnt, pass and timeout, then go to WR_REQ.
- WR_REQ:
  - Assert AWVALID and WVALID together.
  - Each valid is dropped independently on its own handshake. Track aw_done and w_done separately, so AWREADY and WREADY may arrive in any order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP: BREADY=1. On BVALID, BRESP≠OKAY increments err_cnt. Then i++ and go to WR_REQ; after the last register, set i=0 and go to RD_REQ.
- RD_REQ: ARVALID=1. On ARREADY, go to RD_RESP.
- RD_RESP: RREADY=1. On RVALID, increment err_cnt if RDATA≠seed+i or RRESP≠OKAY; both conditions true on one beat counts once. Then i++ or go to FINISH.
- FINISH: pulse done, set pass = (err_cnt==0 && !timeout), then go to IDLE.
- Timeout:
  - A phase counter clears on every state entry and increments while the awaited handshake is absent.
  - At C_TIMEOUT: set timeout=1, deassert all valids/readies and go to FINISH.
  - The slave is then in an undefined protocol state; assert reset before the next start.
- Address and data outputs are stable while their VALID is high. VALID never depends combinationally on READY.

## Timing
- Reset values:
  - busy=0, done=0, pass=0, err_cnt=0, timeout=0.
  - All VALID and READY outputs = 0.
  - AWADDR, ARADDR and WDATA = 0; state = IDLE.
- Reset mid-test aborts immediately to the reset values on the next edge; done is not pulsed.
- Valids assert in the cycle after the state is entered. Registered outputs only.
- With a zero-wait slave (readies tied high, responses returned the cycle after the request):
  - each write takes 2 cycles and each read takes 2 cycles;
  - done pulses exactly 17 cycles after the start edge, with C_NUM_REGS=4.
- busy is high from the cycle after start through the done cycle.
- A start pulse while busy=1 has no effect.

## Test plan
- Zero-wait slave, seed=32'h1: writes 1,2,3,4 to 0x0/0x4/0x8/0xC; readback matches → done at cycle 17, pass=1, err_cnt=0.
- Slave register 2 stuck at 0, seed=32'hFFFF_FFFE: write data FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001; the readback of register 2 is then 0 = expected (wrap-around case) → pass=1. Repeat with seed=32'h10 → err_cnt=1, pass=0.
- AWREADY 3 cycles after WREADY on one write, then the reverse order on the next → each address and data transferred exactly once, pass=1.
- BRESP=SLVERR on register 1, and RRESP=SLVERR plus wrong data on register 3 → err_cnt=2, pass=0.
- Slave never asserts ARREADY, C_TIMEOUT=15 → ARVALID drops after 15 waiting cycles, timeout=1, pass=0, done pulses once.
- Reset asserted during WR_RESP → all outputs at reset values the next cycle; a fresh start then completes with pass=1.
